// File: rtl/vedic_div_sequencer.sv
// rtl/vedic_div_sequencer.sv - sequential restoring divider with power-of-ten divisor classification
module vedic_div_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic [10:0]        power10_value,
    output logic signed [11:0] difference,
    output logic               is_near_power10,
    output logic [15:0]        near_count
);
    localparam int IW = $clog2(WIDTH);
    localparam int NW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ANALYZE, DIVIDE, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  dvd;
    logic [WIDTH-1:0]  dvs;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  rem;
    logic [IW-1:0]     idx;

    logic [NW-1:0]     sig_bits;
    logic [10:0]       p_val;
    logic signed [11:0] diff_val;
    logic              near_val;
    logic [WIDTH:0]    rem_shift;
    logic              sub_ok;
    logic [WIDTH-1:0]  rem_sub;

    // Number of significant dividend bits: position of the highest set bit plus one.
    always_comb begin
        sig_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dvd[i]) sig_bits = NW'(i + 1);
        end
    end

    always_comb begin
        p_val    = 11'd10;
        diff_val = '0;
        near_val = 1'b0;
        if (dvs < WIDTH'(20)) begin
            p_val    = 11'd10;
            diff_val = 12'sd10 - $signed({1'b0, dvs[10:0]});
            near_val = (dvs >= WIDTH'(8)) && (dvs <= WIDTH'(12));
        end else if (dvs < WIDTH'(200)) begin
            p_val    = 11'd100;
            diff_val = 12'sd100 - $signed({1'b0, dvs[10:0]});
            near_val = (dvs >= WIDTH'(71)) && (dvs <= WIDTH'(129));
        end else if (dvs < WIDTH'(2000)) begin
            p_val    = 11'd1000;
            diff_val = 12'sd1000 - $signed({1'b0, dvs[10:0]});
            near_val = (dvs >= WIDTH'(701)) && (dvs <= WIDTH'(1299));
        end
    end

    // The shifted remainder needs one extra bit; the difference always fits in WIDTH bits.
    always_comb begin
        rem_shift = {rem, dvd[idx]};
        sub_ok    = rem_shift[WIDTH] || (rem_shift[WIDTH-1:0] >= dvs);
        rem_sub   = rem_shift[WIDTH-1:0] - dvs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            in_ready        <= 1'b1;
            out_valid       <= 1'b0;
            dvd             <= '0;
            dvs             <= '0;
            q               <= '0;
            rem             <= '0;
            idx             <= '0;
            div_by_zero     <= 1'b0;
            power10_value   <= 11'd10;
            difference      <= '0;
            is_near_power10 <= 1'b0;
            near_count      <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd         <= dividend;
                        dvs         <= divisor;
                        q           <= '0;
                        rem         <= '0;
                        div_by_zero <= 1'b0;
                        in_ready    <= 1'b0;
                        state       <= ANALYZE;
                    end
                end
                ANALYZE: begin
                    power10_value   <= p_val;
                    difference      <= diff_val;
                    is_near_power10 <= near_val;
                    if (dvs == '0) begin
                        div_by_zero <= 1'b1;
                        q           <= '1;
                        rem         <= dvd;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else if (sig_bits == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx   <= IW'(sig_bits - NW'(1));
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (sub_ok) begin
                        rem    <= rem_sub;
                        q[idx] <= 1'b1;
                    end else begin
                        rem <= rem_shift[WIDTH-1:0];
                    end
                    if (idx == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                        if (is_near_power10 && near_count != 16'hFFFF) begin
                            near_count <= near_count + 16'd1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign quotient  = q;
    assign remainder = rem;
endmodule

// File: tb/tb_vedic_div_sequencer.sv
// tb/tb_vedic_div_sequencer.sv - directed self-checking bench for vedic_div_sequencer
module tb_vedic_div_sequencer;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        dividend;
    logic [15:0]        divisor;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        quotient;
    logic [15:0]        remainder;
    logic               div_by_zero;
    logic [10:0]        power10_value;
    logic signed [11:0] difference;
    logic               is_near_power10;
    logic [15:0]        near_count;

    int checks   = 0;
    int failures = 0;
    int exp_nc   = 0;

    vedic_div_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .power10_value(power10_value),
        .difference(difference), .is_near_power10(is_near_power10),
        .near_count(near_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Drive an operand pair at a negedge; returns at the negedge of cycle 1.
    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_busy", 32'(in_ready), 0);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int stall,
                          input int exp_lat, input int exp_q, input int exp_r, input int exp_dbz,
                          input int exp_p, input int exp_diff, input int exp_near);
        int cyc;
        out_ready = (stall == 0);
        accept(a, b);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        check("quotient", 32'(quotient), 32'(exp_q));
        check("remainder", 32'(remainder), 32'(exp_r));
        check("div_by_zero", 32'(div_by_zero), 32'(exp_dbz));
        check("power10", 32'(power10_value), 32'(exp_p));
        check("difference", 32'($signed(difference)), 32'(exp_diff));
        check("near", 32'(is_near_power10), 32'(exp_near));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 1);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_q", 32'(quotient), 32'(exp_q));
            check("stall_r", 32'(remainder), 32'(exp_r));
            check("stall_count", 32'(near_count), 32'(exp_nc));
        end
        out_ready = 1'b1;
        @(negedge clk);
        if (exp_near != 0) exp_nc++;
        check("valid_after_hs", 32'(out_valid), 0);
        check("in_ready_after_hs", 32'(in_ready), 1);
        check("near_count", 32'(near_count), 32'(exp_nc));
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_p", 32'(power10_value), 10);
        check("rst_count", 32'(near_count), 0);
        rst_n = 1'b1;

        run_op(16'd1000, 16'd10, 0, 12, 100, 0, 0, 10, 0, 1);
        run_op(16'hFFFF, 16'd7, 0, 18, 9362, 1, 0, 10, 3, 0);
        run_op(16'h1234, 16'd0, 0, 2, 16'hFFFF, 16'h1234, 1, 10, 10, 0);
        run_op(16'd5, 16'd150, 0, 5, 0, 5, 0, 100, -50, 0);
        run_op(16'd5, 16'd1300, 0, 5, 0, 5, 0, 1000, -300, 0);
        run_op(16'd0, 16'd9, 0, 2, 0, 0, 0, 10, 1, 1);
        run_op(16'd1000, 16'd99, 5, 12, 10, 10, 0, 100, 1, 1);

        // Flush a near-power-of-ten operation midway through its divide.
        out_ready = 1'b1;
        accept(16'h8000, 16'd10);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 1);
        check("flush_valid", 32'(out_valid), 0);
        repeat (20) @(negedge clk);
        check("flush_no_valid", 32'(out_valid), 0);
        check("flush_count", 32'(near_count), 32'(exp_nc));
        run_op(16'hABCD, 16'd18, 0, 18, 2443, 7, 0, 10, -8, 0);

        // Asynchronous reset in the middle of a divide.
        accept(16'hFFFF, 16'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_q", 32'(quotient), 0);
        check("arst_r", 32'(remainder), 0);
        check("arst_dbz", 32'(div_by_zero), 0);
        check("arst_p", 32'(power10_value), 10);
        check("arst_diff", 32'($signed(difference)), 0);
        check("arst_near", 32'(is_near_power10), 0);
        check("arst_count", 32'(near_count), 0);
        exp_nc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h00FF, 16'd15, 0, 10, 17, 0, 0, 10, -5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
